// File: rtl/button_repeater_pkg.sv
// Shared types and helpers for the button auto-repeat block.
package button_repeater_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Tick-counter width: wide enough for the larger of the delay/rate periods.
  function automatic int cnt_width(input int delay_ticks, input int rate_ticks);
    int m;
    m = (delay_ticks > rate_ticks) ? delay_ticks : rate_ticks;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/button_repeater_if.sv
// Button levels and repeat enables in; press/repeat pulses and held levels out.
interface button_repeater_if #(
  parameter int N = 4
);
  logic [N-1:0] Btn;
  logic [N-1:0] RepeatEn;
  logic [N-1:0] Pulse;
  logic [N-1:0] Held;

  modport master (output Btn, output RepeatEn, input Pulse, input Held);
  modport slave  (input Btn, input RepeatEn, output Pulse, output Held);
endinterface

// File: rtl/button_repeater_channel.sv
// One channel: press pulse 1 cycle after Btn rises, then timed auto-repeat pulses.
// No backpressure: pulses are fire-and-forget single-cycle events.
module repeat_channel
  import button_repeater_pkg::*;
#(
  parameter int DELAY_TICKS = 500,
  parameter int RATE_TICKS  = 100
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic btn,
  input  logic repeat_en,
  output logic pulse,
  output logic held
);
  localparam int CW = cnt_width(DELAY_TICKS, RATE_TICKS);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_TICKS - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(RATE_TICKS - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn) begin
            state <= HOLD;
            cnt   <= '0;
            pulse <= 1'b1;
            held  <= 1'b1;
          end
        end
        HOLD: begin
          // Release wins over any tick arriving in the same cycle.
          if (!btn) begin
            state <= IDLE;
            held  <= 1'b0;
          end else if (repeat_en && tick) begin
            if (cnt == DELAY_LAST) begin
              state <= REPEAT;
              cnt   <= '0;
              pulse <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        REPEAT: begin
          if (!btn) begin
            state <= IDLE;
            held  <= 1'b0;
          end else if (!repeat_en) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == RATE_LAST) begin
              cnt   <= '0;
              pulse <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_repeater.sv
// N-channel button repeater sharing one free-running ms timebase; pulses lag Btn by 1 cycle.
// No backpressure: outputs are registered levels/pulses.
module button_repeater
  import button_repeater_pkg::*;
#(
  parameter int N           = 4,
  parameter int CLK_DIV     = 50000,
  parameter int DELAY_TICKS = 500,
  parameter int RATE_TICKS  = 100
) (
  input logic               Clk,
  input logic               Reset,
  button_repeater_if.slave  bus
);
  localparam int TBW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TBW-1:0] TB_LAST = TBW'(CLK_DIV - 1);

  logic [TBW-1:0] tb_cnt;
  logic           tick;
  logic [N-1:0]   pulse_v;
  logic [N-1:0]   held_v;

  // Free-running: never realigned to button activity, only to Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tb_cnt <= '0;
    end else if (tb_cnt == TB_LAST) begin
      tb_cnt <= '0;
    end else begin
      tb_cnt <= tb_cnt + TBW'(1);
    end
  end

  assign tick = (tb_cnt == TB_LAST);

  for (genvar i = 0; i < N; i++) begin : g_ch
    repeat_channel #(
      .DELAY_TICKS (DELAY_TICKS),
      .RATE_TICKS  (RATE_TICKS)
    ) u_ch (
      .Clk       (Clk),
      .Reset     (Reset),
      .tick      (tick),
      .btn       (bus.Btn[i]),
      .repeat_en (bus.RepeatEn[i]),
      .pulse     (pulse_v[i]),
      .held      (held_v[i])
    );
  end

  assign bus.Pulse = pulse_v;
  assign bus.Held  = held_v;

endmodule

// File: tb/tb_button_repeater.sv
// Directed bench for button_repeater with CLK_DIV=4, DELAY_TICKS=3, RATE_TICKS=2.
module tb_button_repeater;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   mcnt;       // reference copy of the timebase phase
  int   pq[$];      // step numbers at which Pulse was seen
  int   hcnt;

  button_repeater_if #(.N(4)) bus ();

  button_repeater #(
    .N           (4),
    .CLK_DIV     (4),
    .DELAY_TICKS (3),
    .RATE_TICKS  (2)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    mcnt = rst ? 0 : ((mcnt == 3) ? 0 : mcnt + 1);
    #1;
  endtask

  task automatic idle_steps(input int n);
    bus.Btn      = '0;
    bus.RepeatEn = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic record(input int ch, input logic en, input int hold, input int total);
    pq.delete();
    hcnt = 0;
    bus.RepeatEn[ch] = en;
    bus.Btn[ch]      = 1'b1;
    for (int s = 1; s <= total; s++) begin
      step();
      if (bus.Pulse[ch]) pq.push_back(s);
      if (bus.Held[ch]) hcnt++;
      if (s == hold) bus.Btn[ch] = 1'b0;
    end
    bus.RepeatEn[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Btn = '0;
    bus.RepeatEn = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.Pulse !== 4'b0000) begin
        errors++; $display("FAIL reset_pulse: got %b expected 0000", bus.Pulse);
      end
      checks++;
      if (bus.Held !== 4'b0000) begin
        errors++; $display("FAIL reset_held: got %b expected 0000", bus.Held);
      end
    end
    rst = 1'b0;
    // Tick first appears in the 4th cycle after deassertion.
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (dut.tick !== (c == 4)) begin
        errors++; $display("FAIL reset_tick_phase c=%0d: got %b expected %b", c, dut.tick, (c == 4));
      end
      if (c < 4) step();
    end
  endtask

  task automatic test_single_press();
    record(0, 1'b0, 5, 10);
    checks++;
    if (pq.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d expected 1", pq.size());
    end
    checks++;
    if (pq.size() > 0 && pq[0] != 1) begin
      errors++; $display("FAIL single_latency: got %0d expected 1", pq[0]);
    end
    checks++;
    if (hcnt != 5) begin
      errors++; $display("FAIL single_held: got %0d expected 5", hcnt);
    end
    checks++;
    if (bus.Held[0] !== 1'b0) begin
      errors++; $display("FAIL single_held_end: got %b expected 0", bus.Held[0]);
    end
  endtask

  task automatic test_repeat();
    record(1, 1'b1, 60, 70);
    // Pulses at 1, then 1+a+8 (a = 1..4 ticks phase), then every 8 up to step 60.
    checks++;
    if (pq.size() < 7 || pq.size() > 8) begin
      errors++; $display("FAIL repeat_count: got %0d expected 7..8", pq.size());
    end
    if (pq.size() >= 2) begin
      checks++;
      if (pq[0] != 1) begin
        errors++; $display("FAIL repeat_first: got %0d expected 1", pq[0]);
      end
      checks++;
      if (pq[1] - pq[0] < 9 || pq[1] - pq[0] > 12) begin
        errors++; $display("FAIL repeat_first_gap: got %0d expected 9..12", pq[1] - pq[0]);
      end
      for (int i = 2; i < pq.size(); i++) begin
        checks++;
        if (pq[i] - pq[i-1] != 8) begin
          errors++; $display("FAIL repeat_gap%0d: got %0d expected 8", i, pq[i] - pq[i-1]);
        end
      end
      checks++;
      if (pq[pq.size()-1] > 60 || pq[pq.size()-1] <= 52) begin
        errors++; $display("FAIL repeat_last: got %0d expected 53..60", pq[pq.size()-1]);
      end
    end
    checks++;
    if (hcnt != 60) begin
      errors++; $display("FAIL repeat_held: got %0d expected 60", hcnt);
    end
  endtask

  task automatic test_no_repeat();
    record(2, 1'b0, 60, 70);
    checks++;
    if (pq.size() != 1) begin
      errors++; $display("FAIL norep_count: got %0d expected 1", pq.size());
    end
    checks++;
    if (pq.size() > 0 && pq[0] != 1) begin
      errors++; $display("FAIL norep_latency: got %0d expected 1", pq[0]);
    end
    checks++;
    if (hcnt != 60) begin
      errors++; $display("FAIL norep_held: got %0d expected 60", hcnt);
    end
  endtask

  task automatic test_repeat_disable();
    int seen;
    int pc;
    int hc;
    seen = 0;
    bus.RepeatEn[1] = 1'b1;
    bus.Btn[1] = 1'b1;
    for (int s = 0; s < 30 && seen < 2; s++) begin
      step();
      if (bus.Pulse[1]) seen++;
    end
    checks++;
    if (seen < 2) begin
      errors++; $display("FAIL disable_wait: got %0d pulses expected 2", seen);
    end
    bus.RepeatEn[1] = 1'b0;
    pc = 0;
    hc = 0;
    for (int s = 0; s < 30; s++) begin
      step();
      if (bus.Pulse[1]) pc++;
      if (bus.Held[1]) hc++;
    end
    checks++;
    if (pc != 0) begin
      errors++; $display("FAIL disable_pulses: got %0d expected 0", pc);
    end
    checks++;
    if (hc != 30) begin
      errors++; $display("FAIL disable_held: got %0d expected 30", hc);
    end
    bus.Btn[1] = 1'b0;
    step();
    checks++;
    if (bus.Held[1] !== 1'b0) begin
      errors++; $display("FAIL disable_release: got %b expected 0", bus.Held[1]);
    end
  endtask

  task automatic test_release_on_tick();
    int  ticks;
    logic done;
    ticks = 0;
    done = 1'b0;
    bus.RepeatEn[3] = 1'b1;
    bus.Btn[3] = 1'b1;
    step();
    checks++;
    if (bus.Pulse[3] !== 1'b1) begin
      errors++; $display("FAIL rel_tick_press: got %b expected 1", bus.Pulse[3]);
    end
    // Drop Btn exactly at the third tick, the one that would fire the first repeat.
    for (int s = 0; s < 20 && !done; s++) begin
      if (mcnt == 3) ticks++;
      if (ticks == 3) begin
        bus.Btn[3] = 1'b0;
        done = 1'b1;
      end
      step();
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL rel_tick_wait: got %0d ticks expected 3", ticks);
    end
    checks++;
    if (bus.Pulse[3] !== 1'b0) begin
      errors++; $display("FAIL rel_tick_pulse: got %b expected 0", bus.Pulse[3]);
    end
    checks++;
    if (bus.Held[3] !== 1'b0) begin
      errors++; $display("FAIL rel_tick_held: got %b expected 0", bus.Held[3]);
    end
    step();
    checks++;
    if (bus.Pulse[3] !== 1'b0) begin
      errors++; $display("FAIL rel_tick_after: got %b expected 0", bus.Pulse[3]);
    end
    bus.RepeatEn[3] = 1'b0;
  endtask

  task automatic test_reset_mid_repeat();
    int seen;
    seen = 0;
    bus.RepeatEn[1] = 1'b1;
    bus.Btn[1] = 1'b1;
    for (int s = 0; s < 30 && seen < 2; s++) begin
      step();
      if (bus.Pulse[1]) seen++;
    end
    checks++;
    if (seen < 2) begin
      errors++; $display("FAIL midrst_wait: got %0d pulses expected 2", seen);
    end
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (bus.Pulse !== 4'b0000) begin
      errors++; $display("FAIL midrst_pulse: got %b expected 0000", bus.Pulse);
    end
    checks++;
    if (bus.Held !== 4'b0000) begin
      errors++; $display("FAIL midrst_held: got %b expected 0000", bus.Held);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.Pulse[1] !== 1'b1) begin
      errors++; $display("FAIL midrst_fresh: got %b expected 1", bus.Pulse[1]);
    end
    step();
    checks++;
    if (bus.Pulse[1] !== 1'b0 || bus.Held[1] !== 1'b1) begin
      errors++; $display("FAIL midrst_after: got pulse=%b held=%b expected pulse=0 held=1",
                         bus.Pulse[1], bus.Held[1]);
    end
    bus.Btn[1] = 1'b0;
    bus.RepeatEn[1] = 1'b0;
  endtask

  task automatic test_simultaneous();
    bus.Btn = 4'b0101;
    step();
    checks++;
    if (bus.Pulse !== 4'b0101) begin
      errors++; $display("FAIL simul_first: got %b expected 0101", bus.Pulse);
    end
    bus.Btn = 4'b1111;
    step();
    checks++;
    if (bus.Pulse !== 4'b1010) begin
      errors++; $display("FAIL simul_second: got %b expected 1010", bus.Pulse);
    end
    checks++;
    if (bus.Held !== 4'b1111) begin
      errors++; $display("FAIL simul_held: got %b expected 1111", bus.Held);
    end
    step();
    checks++;
    if (bus.Pulse !== 4'b0000) begin
      errors++; $display("FAIL simul_quiet: got %b expected 0000", bus.Pulse);
    end
    bus.Btn = 4'b0000;
    step();
    checks++;
    if (bus.Held !== 4'b0000) begin
      errors++; $display("FAIL simul_release: got %b expected 0000", bus.Held);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mcnt = 0;
    rst = 1'b1;
    bus.Btn = '0;
    bus.RepeatEn = '0;
    test_reset();
    test_single_press();
    idle_steps(3);
    test_repeat();
    idle_steps(3);
    test_no_repeat();
    idle_steps(3);
    test_repeat_disable();
    idle_steps(3);
    test_release_on_tick();
    idle_steps(3);
    test_reset_mid_repeat();
    idle_steps(3);
    test_simultaneous();
    idle_steps(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
